pipe_stage_reg: RTL

- Parametrised pipeline stage register. It generalises the fixed-field ID/EX-style stall/flush registers.
- Carries one control vector and one data payload between CPU stages, with a valid/ready handshake and an optional skid buffer.
- Flush forces the control vector to a bubble value. Selected data bits (e.g. PC, CSR) are still captured from the input on flush.
- A flush that arrives during a stall is deferred until the stall ends, not lost. An applied-flush counter is provided for performance monitoring.

---
 rtl/pipe_stage_reg_if.sv | 13 +
 rtl/pipe_stage_reg.sv | 119 +++++++++++
 2 files changed

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready link carrying one control vector and one data payload between pipeline stages.
interface pipe_stage_reg_if #(
    parameter int unsigned CTRL_W = 32,
    parameter int unsigned DATA_W = 160
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Parametrised CPU pipeline stage register: valid/ready handshake, optional skid entry,
// flush-to-bubble with selectively kept data bits, deferred flush under stall, flush counter.
module pipe_stage_reg #(
    parameter int unsigned       CTRL_W           = 32,
    parameter int unsigned       DATA_W           = 160,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE      = '0,
    parameter logic [DATA_W-1:0] DATA_KEEP        = '0,
    parameter bit                SKID             = 1'b1,
    parameter bit                FLUSH_OVER_STALL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    pipe_stage_reg_if.slave   up,
    pipe_stage_reg_if.master  dn,
    output logic [1:0]        occupancy,
    output logic              flush_pend,
    output logic [15:0]       flush_cnt
);
    localparam int unsigned CNT_W = 16;

    logic              m_valid_q, m_valid_d;
    logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
    logic [DATA_W-1:0] m_data_q,  m_data_d;
    logic              s_valid_q, s_valid_d;
    logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
    logic [DATA_W-1:0] s_data_q,  s_data_d;
    logic              flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0]  flush_cnt_q,  flush_cnt_d;

    logic in_ready_c;
    logic accept_c;
    logic drain_c;
    logic eff_flush_c;

    // With a skid entry, ready only reflects skid occupancy, cutting the out_ready->in_ready path.
    assign in_ready_c  = SKID ? ~s_valid_q
                              : (~stall & (~m_valid_q | dn.ready) & ~flush_pend_q);
    assign accept_c    = up.valid & in_ready_c;
    assign drain_c     = m_valid_q & dn.ready & ~stall;
    assign eff_flush_c = (flush | flush_pend_q) & (~stall | FLUSH_OVER_STALL);

    always_comb begin
        m_valid_d    = m_valid_q;
        m_ctrl_d     = m_ctrl_q;
        m_data_d     = m_data_q;
        s_valid_d    = s_valid_q;
        s_ctrl_d     = s_ctrl_q;
        s_data_d     = s_data_q;
        flush_pend_d = flush_pend_q;
        flush_cnt_d  = flush_cnt_q;

        if (eff_flush_c) begin
            // Same-cycle accepted item is dropped; only the keep bits of in_data survive.
            m_valid_d    = 1'b0;
            s_valid_d    = 1'b0;
            m_ctrl_d     = CTRL_BUBBLE;
            m_data_d     = up.data & DATA_KEEP;
            flush_pend_d = 1'b0;
            if (flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else if (stall) begin
            if (flush) flush_pend_d = 1'b1;
            if (accept_c) begin
                s_valid_d = 1'b1;
                s_ctrl_d  = up.ctrl;
                s_data_d  = up.data;
            end
        end else if (s_valid_q && (drain_c || !m_valid_q)) begin
            m_valid_d = 1'b1;
            m_ctrl_d  = s_ctrl_q;
            m_data_d  = s_data_q;
            s_valid_d = 1'b0;
        end else if (accept_c && (drain_c || !m_valid_q)) begin
            m_valid_d = 1'b1;
            m_ctrl_d  = up.ctrl;
            m_data_d  = up.data;
        end else if (accept_c) begin
            s_valid_d = 1'b1;
            s_ctrl_d  = up.ctrl;
            s_data_d  = up.data;
        end else if (drain_c) begin
            m_valid_d = 1'b0;
            m_ctrl_d  = CTRL_BUBBLE;
        end

        if (!SKID) s_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q    <= 1'b0;
            m_ctrl_q     <= CTRL_BUBBLE;
            m_data_q     <= '0;
            s_valid_q    <= 1'b0;
            s_ctrl_q     <= CTRL_BUBBLE;
            s_data_q     <= '0;
            flush_pend_q <= 1'b0;
            flush_cnt_q  <= '0;
        end else begin
            m_valid_q    <= m_valid_d;
            m_ctrl_q     <= m_ctrl_d;
            m_data_q     <= m_data_d;
            s_valid_q    <= s_valid_d;
            s_ctrl_q     <= s_ctrl_d;
            s_data_q     <= s_data_d;
            flush_pend_q <= flush_pend_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign up.ready   = in_ready_c;
    assign dn.valid   = m_valid_q;
    assign dn.ctrl    = m_ctrl_q;
    assign dn.data    = m_data_q;
    assign occupancy  = 2'(m_valid_q) + 2'(s_valid_q);
    assign flush_pend = flush_pend_q;
    assign flush_cnt  = flush_cnt_q;
endmodule
